// File: rtl/skip_mask_gen_pkg.sv
// Shared definitions for the clock-skip mask generator: FSM states,
// default ring length and the skip-count width derivation.
package skip_pkg;

    localparam int LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // A count of 0..len skipped pulses needs clog2(len+1) bits.
    function automatic int nw_of(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/skip_mask_gen_if.sv
// Control/status bundle between the skip-mask generator and its host/ring.
// WR is a single-cycle request strobe with N as payload: it is accepted only on
// an edge where BUSY=0; a WR seen while BUSY=1 is dropped and raises ERR.
interface skip_mask_gen_if #(
    parameter int LEN = skip_pkg::LEN_DEF,
    parameter int NW  = skip_pkg::nw_of(LEN)
);
    import skip_pkg::*;

    logic           WR;
    logic [NW-1:0]  N;
    logic           EN;
    logic           B0;
    logic [LEN-1:0] MASK;
    logic           E;
    logic           BUSY;
    logic           PEND;
    logic           ERR;
    state_t         STATE;

    modport slave (
        input  WR, N, EN, B0,
        output MASK, E, BUSY, PEND, ERR, STATE
    );

    modport master (
        output WR, N, EN, B0,
        input  MASK, E, BUSY, PEND, ERR, STATE
    );

endinterface

// File: rtl/skip_mask_gen_bres_step.sv
// One combinational Bresenham step: adds the skip count to the accumulator and
// emits a mask bit whenever the running sum wraps past the ring length.
module skip_bres_step #(
    parameter int LEN = skip_pkg::LEN_DEF,
    parameter int NW  = skip_pkg::nw_of(LEN)
) (
    input  logic [NW-1:0] acc_i,
    input  logic [NW-1:0] nc_i,
    output logic [NW-1:0] acc_o,
    output logic          bit_o
);

    // One extra bit so acc (< LEN) plus nc (<= LEN) never overflows.
    logic [NW:0] sum;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, nc_i};
        bit_o = 1'b0;
        acc_o = sum[NW-1:0];
        if (sum >= (NW+1)'(LEN)) begin
            bit_o = 1'b1;
            acc_o = NW'(sum - (NW+1)'(LEN));
        end
    end

endmodule

// File: rtl/skip_mask_gen.sv
// Builds an evenly spread LEN-bit skip mask one bit per cycle into a shadow
// register and commits it to the ring only at a frame boundary.
module skip_mask_gen
    import skip_pkg::*;
#(
    parameter int LEN = LEN_DEF,
    parameter int NW  = nw_of(LEN)
) (
    input logic              iCLK,
    input logic              RST,
    skip_mask_gen_if.slave   bus
);

    localparam int IW = $clog2(LEN);

    state_t         state_q, state_d;
    logic [NW-1:0]  acc_q, acc_d;
    logic [NW-1:0]  nc_q, nc_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [LEN-1:0] shadow_q, shadow_d;
    logic [LEN-1:0] mask_q, mask_d;
    logic           err_q, err_d;
    logic           e_q;

    logic [NW-1:0]  step_acc;
    logic           step_bit;

    skip_bres_step #(
        .LEN (LEN),
        .NW  (NW)
    ) u_step (
        .acc_i (acc_q),
        .nc_i  (nc_q),
        .acc_o (step_acc),
        .bit_o (step_bit)
    );

    always_ff @(posedge iCLK) begin
        if (RST) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            nc_q     <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
            e_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            nc_q     <= nc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            e_q      <= bus.EN;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        nc_d     = nc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.WR) begin
                    nc_d    = (bus.N > NW'(LEN)) ? NW'(LEN) : bus.N;
                    err_d   = (bus.N > NW'(LEN));
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (bus.WR) err_d = 1'b1;
                shadow_d[idx_q] = step_bit;
                acc_d           = step_acc;
                idx_d           = idx_q + IW'(1);
                if (idx_q == IW'(LEN - 1)) state_d = WAIT;
            end
            WAIT: begin
                if (bus.WR) err_d = 1'b1;
                // Registered E, not EN: the ring only sees E, so a frame
                // boundary is judged from what the ring is actually doing.
                if (!e_q || bus.B0) begin
                    mask_d  = shadow_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.MASK  = mask_q;
    assign bus.E     = e_q;
    assign bus.BUSY  = (state_q != IDLE);
    assign bus.PEND  = (state_q == WAIT);
    assign bus.ERR   = err_q;
    assign bus.STATE = state_q;

endmodule

// File: tb/tb_skip_mask_gen.sv
// Directed bench for skip_mask_gen: hand-computed masks, commit timing against a
// simple ring frame marker, error and reset cases.
module tb_skip_mask_gen;
    import skip_pkg::*;

    logic iCLK;
    logic RST;
    int   n_cmp;
    int   n_err;

    skip_mask_gen_if #(.LEN(16)) bus ();

    skip_mask_gen #(.LEN(16)) dut (
        .iCLK (iCLK),
        .RST  (RST),
        .bus  (bus)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic load(input logic [4:0] n);
        bus.WR = 1'b1;
        bus.N  = n;
        tick();
        bus.WR = 1'b0;
    endtask

    task automatic wait_commit(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.BUSY) break;
        end
        check_eq(tag, 32'(bus.BUSY), 32'd0);
    endtask

    task automatic wait_pend(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.PEND) break;
        end
        check_eq(tag, 32'(bus.PEND), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mask"}, 32'(bus.MASK), 32'h0);
        check_eq({tag, "_e"},    32'(bus.E),    32'd0);
        check_eq({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check_eq({tag, "_pend"}, 32'(bus.PEND), 32'd0);
        check_eq({tag, "_err"},  32'(bus.ERR),  32'd0);
    endtask

    logic [4:0]  t2_n    [3] = '{5'd1, 5'd8, 5'd0};
    logic [15:0] t2_mask [3] = '{16'h8000, 16'hAAAA, 16'h0000};
    int          dropped;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        RST    = 1'b1;
        bus.WR = 1'b0;
        bus.N  = '0;
        bus.EN = 1'b0;
        bus.B0 = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        check_eq("reset_state", 32'(bus.STATE), 32'(IDLE));
        RST = 1'b0;
        tick();

        // 1: N=4 timing, commit with EN=0 at edge 17
        load(5'd4);
        check_eq("t1_busy_e0", 32'(bus.BUSY), 32'd1);
        check_eq("t1_state_e0", 32'(bus.STATE), 32'(GEN));
        check_eq("t1_pend_e0", 32'(bus.PEND), 32'd0);
        repeat (15) tick();
        check_eq("t1_pend_e15", 32'(bus.PEND), 32'd0);
        check_eq("t1_mask_e15", 32'(bus.MASK), 32'h0);
        tick();
        check_eq("t1_pend_e16", 32'(bus.PEND), 32'd1);
        check_eq("t1_mask_e16", 32'(bus.MASK), 32'h0);
        tick();
        check_eq("t1_mask_e17", 32'(bus.MASK), 32'h8888);
        check_eq("t1_busy_e17", 32'(bus.BUSY), 32'd0);
        check_eq("t1_pend_e17", 32'(bus.PEND), 32'd0);
        check_eq("t1_err_e17", 32'(bus.ERR), 32'd0);

        // 2: table of counts
        for (int i = 0; i < 3; i++) begin
            load(t2_n[i]);
            wait_commit("t2_commit");
            check_eq("t2_mask", 32'(bus.MASK), 32'(t2_mask[i]));
            check_eq("t2_pop", 32'($countones(bus.MASK)), 32'(t2_n[i]));
        end

        // 3: EN=1, ring frame marker every 16 cycles, N=3
        bus.EN = 1'b1;
        tick();
        tick();
        bus.B0 = 1'b1;
        load(5'd3);
        check_eq("t3_busy", 32'(bus.BUSY), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            bus.B0 = (k % 16 == 0);
            tick();
            if (k >= 16 && k < 32) begin
                check_eq("t3_pend_hold", 32'(bus.PEND), 32'd1);
                check_eq("t3_mask_hold", 32'(bus.MASK), 32'h0);
            end
        end
        check_eq("t3_mask_commit", 32'(bus.MASK), 32'h8420);
        check_eq("t3_pend_commit", 32'(bus.PEND), 32'd0);
        check_eq("t3_busy_commit", 32'(bus.BUSY), 32'd0);
        dropped = 0;
        for (int s = 0; s < 16; s++) begin
            bus.B0 = (s == 0);
            tick();
            if (bus.E && bus.MASK[s]) dropped++;
        end
        bus.B0 = 1'b0;
        check_eq("t3_dropped", 32'(dropped), 32'd3);
        check_eq("t3_mask_stable", 32'(bus.MASK), 32'h8420);

        // 4: over-range count then a valid one
        bus.EN = 1'b0;
        tick();
        tick();
        load(5'd20);
        check_eq("t4_err_set", 32'(bus.ERR), 32'd1);
        wait_commit("t4_commit_a");
        check_eq("t4_mask_full", 32'(bus.MASK), 32'hFFFF);
        check_eq("t4_err_kept", 32'(bus.ERR), 32'd1);
        load(5'd2);
        check_eq("t4_err_clr", 32'(bus.ERR), 32'd0);
        wait_commit("t4_commit_b");
        check_eq("t4_mask_2", 32'(bus.MASK), 32'h8080);

        // 5: writes while busy are dropped
        bus.EN = 1'b1;
        tick();
        load(5'd4);
        repeat (4) tick();
        bus.WR = 1'b1;
        bus.N  = 5'd8;
        tick();
        bus.WR = 1'b0;
        check_eq("t5_err_gen", 32'(bus.ERR), 32'd1);
        check_eq("t5_busy_gen", 32'(bus.BUSY), 32'd1);
        wait_pend("t5_pend");
        bus.WR = 1'b1;
        bus.N  = 5'd1;
        tick();
        bus.WR = 1'b0;
        check_eq("t5_err_wait", 32'(bus.ERR), 32'd1);
        check_eq("t5_pend_wait", 32'(bus.PEND), 32'd1);
        check_eq("t5_mask_old", 32'(bus.MASK), 32'h8080);
        bus.B0 = 1'b1;
        tick();
        bus.B0 = 1'b0;
        check_eq("t5_mask_commit", 32'(bus.MASK), 32'h8888);
        check_eq("t5_busy_done", 32'(bus.BUSY), 32'd0);
        load(5'd2);
        check_eq("t5c_err_clr", 32'(bus.ERR), 32'd0);
        wait_pend("t5c_pend");
        bus.WR = 1'b1;
        bus.N  = 5'd1;
        bus.B0 = 1'b1;
        tick();
        bus.WR = 1'b0;
        bus.B0 = 1'b0;
        check_eq("t5c_mask", 32'(bus.MASK), 32'h8080);
        check_eq("t5c_err", 32'(bus.ERR), 32'd1);
        check_eq("t5c_busy", 32'(bus.BUSY), 32'd0);
        tick();
        check_eq("t5c_not_taken", 32'(bus.BUSY), 32'd0);

        // 6: reset during GEN and during WAIT
        load(5'd4);
        repeat (7) tick();
        RST = 1'b1;
        tick();
        check_all_zero("t6_rst_gen");
        RST    = 1'b0;
        bus.EN = 1'b0;
        repeat (20) tick();
        check_eq("t6_gen_nocommit", 32'(bus.MASK), 32'h0);
        check_eq("t6_gen_idle", 32'(bus.BUSY), 32'd0);
        bus.EN = 1'b1;
        tick();
        load(5'd8);
        wait_pend("t6_pend");
        RST = 1'b1;
        tick();
        check_all_zero("t6_rst_wait");
        RST    = 1'b0;
        bus.B0 = 1'b1;
        repeat (3) tick();
        bus.B0 = 1'b0;
        check_eq("t6_wait_nocommit", 32'(bus.MASK), 32'h0);
        check_eq("t6_wait_idle", 32'(bus.BUSY), 32'd0);
        bus.EN = 1'b0;
        tick();
        load(5'd5);
        wait_commit("t6_commit5");
        check_eq("t6_mask5", 32'(bus.MASK), 32'h9248);
        check_eq("t6_pop5", 32'($countones(bus.MASK)), 32'd5);
        check_eq("t6_first5", 32'(bus.MASK[3:0]), 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skip_mask_gen.md
Name: skip_mask_gen

Overview:
- Upstream control stage for the clock-skip ring. Takes a requested skip count N (pulses to drop per LEN-slot frame) and builds an evenly distributed LEN-bit MASK with a sequential Bresenham accumulator, one bit per cycle.
- Drives the ring's MASK and E inputs.
- A new mask is committed only at a frame boundary, marked by the ring's B0 output, so a frame never runs with a mixed mask.

Parameters:
- LEN, 16, ring length in slots (bits of MASK); must be ≥2.
- NW, $clog2(LEN+1), width of the skip-count input.

Ports:
- iCLK  in  1  clock; all state updates on the posedge.
- RST  in  1  synchronous reset, active-high.
- WR  in  1  load request, single-cycle strobe; N sampled with it.
- N  in  NW  requested skipped pulses per frame, 0..LEN.
- EN  in  1  enable request for the ring.
- B0  in  1  frame-start marker from the ring's oB0.
- MASK  out  LEN  committed skip mask to the ring.
- E  out  1  registered ring enable.
- BUSY  out  1  generation or commit in progress.
- PEND  out  1  generated mask waiting for commit.
- ERR  out  1  sticky error flag.

Behaviour:
- Reset (RST=1 at a posedge): MASK=0, E=0, BUSY=0, PEND=0, ERR=0, state IDLE, acc=0, idx=0, shadow=0. RST overrides everything, including mid-GEN or WAIT; the pending mask is discarded.
- E <= EN at every posedge (1-cycle latency). E is independent of the state machine.
- States:
  - IDLE: waits for a load request.
  - GEN: LEN cycles, computes one shadow bit per cycle.
  - WAIT: mask generated, waiting for the commit point.
- IDLE, WR=1 at edge 0:
  - Capture Nc = min(N, LEN); acc=0; idx=0; go to GEN; BUSY=1 after edge 0.
  - If N>LEN: ERR<=1. Otherwise ERR<=0 (a valid accepted write clears ERR).
- GEN, each edge k=1..LEN:
  - Compute s = acc + Nc, width NW+1, with no overflow.
  - If s ≥ LEN: shadow[idx]<=1 and acc<=s-LEN. Otherwise shadow[idx]<=0 and acc<=s.
  - idx<=idx+1.
  - At edge LEN go to WAIT with PEND=1.
- Result: exactly Nc ones in the mask, the first at index ceil(LEN/Nc)-1.
  - N=0 gives all zeros.
  - N=LEN gives all ones (every pulse skipped while E=1).
- WAIT: commit at the first posedge where (E==0 || B0==1). On that edge MASK<=shadow, PEND<=0, BUSY<=0, go to IDLE.
  - The earliest commit is edge LEN+1 after the accepting edge.
  - B0 is held high for a full iCLK period because the ring advances on the negedge, so a posedge always samples it.
- WR while BUSY=1 (GEN or WAIT): the write is dropped, ERR<=1, and the operation in flight is unaffected.
- WR on the same edge as a commit: counts as BUSY, so it is dropped with ERR set.
- MASK changes only on a commit edge or on reset; it never changes in GEN.
- EN toggles mid-WAIT: the commit condition uses the registered E, not EN.

Decomposition:
- Shared package skip_pkg holds:
  - state enum {IDLE, GEN, WAIT};
  - LEN default constant;
  - NW derivation function.
- One natural sub-module: skip_bres_step, a combinational accumulator step. Inputs acc, Nc; outputs next acc and bit. It is reusable by a future rate-programmable ring controller.

Test Plan:
1. Reset, then WR with N=4 and EN=0 → BUSY rises after edge 0. PEND=1 after edge 16. MASK=16'h8888 at edge 17; BUSY=0, ERR=0.
2. N=1, then N=8, then N=0, each with EN=0 → MASK=16'h8000, then 16'hAAAA, then 16'h0000; each MASK has popcount equal to N.
3. EN=1 with a ring model driving B0 once every 16 cycles; WR with N=3 → PEND is held until the first posedge with B0=1 after generation completes. MASK changes only on that edge, and exactly 3 pulses are dropped in each subsequent frame.
4. WR with N=20 → ERR=1 and MASK=16'hFFFF after commit. A following valid WR with N=2 clears ERR and gives MASK=16'h8080.
5. Second WR during GEN (cycle 5) and again during WAIT → ERR=1, and the first request's mask commits unchanged.
6. RST asserted in GEN at cycle 8, and separately in WAIT → all outputs return to 0 on that edge and no commit occurs; a WR with N=5 afterwards yields exactly 5 ones in MASK, with the first at bit 3.
